// File: rtl/axi4lite_seq.sv
// Script-driven AXI4-Lite master: replays WRITE/POLL/DELAY/END entries from a ROM.
// Entry issue costs FETCH+EXEC (2 cycles); VALIDs hold until their handshake.
module axi4lite_seq #(
    parameter int    N         = 16,
    parameter int    ADDRW     = 8,
    parameter int    DATAW     = 32,
    parameter int    POLL_MAX  = 1024,
    parameter string INIT_FILE = "axi4lite_seq.mem"
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [1:0]             err_code_o,
    output logic [$clog2(N)-1:0]   err_idx_o,
    output logic [ADDRW-1:0]       s_axi_awaddr_o,
    output logic                   s_axi_awvalid_o,
    input  logic                   s_axi_awready_i,
    output logic [DATAW-1:0]       s_axi_wdata_o,
    output logic [DATAW/8-1:0]     s_axi_wstrb_o,
    output logic                   s_axi_wvalid_o,
    input  logic                   s_axi_wready_i,
    input  logic [1:0]             s_axi_bresp_i,
    input  logic                   s_axi_bvalid_i,
    output logic                   s_axi_bready_o,
    output logic [ADDRW-1:0]       s_axi_araddr_o,
    output logic                   s_axi_arvalid_o,
    input  logic                   s_axi_arready_i,
    input  logic [DATAW-1:0]       s_axi_rdata_i,
    input  logic [1:0]             s_axi_rresp_i,
    input  logic                   s_axi_rvalid_i,
    output logic                   s_axi_rready_o
);
    localparam int IW = $clog2(N);
    localparam int EW = 2 + ADDRW + 2 * DATAW;
    localparam int CW = $clog2(POLL_MAX + 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_POLL  = 2'd1;
    localparam logic [1:0] OP_DELAY = 2'd2;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_BRESP = 2'd1;
    localparam logic [1:0] ERR_RRESP = 2'd2;
    localparam logic [1:0] ERR_POLL = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_EXEC, S_WR, S_BRSP, S_RD, S_RRSP, S_DELAY, S_DONE, S_ERR
    } state_t;

    logic [EW-1:0] rom [N];

    state_t           state_q;
    logic [IW-1:0]    idx_q, idx_d, err_idx_q;
    logic [EW-1:0]    rom_q;
    logic [DATAW-1:0] ent_data_q, ent_mask_q, wdata_q;
    logic [ADDRW-1:0] awaddr_q, araddr_q;
    logic [CW-1:0]    attempt_q;
    logic [15:0]      dly_q;
    logic [1:0]       err_code_q;
    logic             done_q, err_q;
    logic             awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

    logic [1:0]       ent_op;
    logic [ADDRW-1:0] ent_addr;
    logic [DATAW-1:0] ent_data, ent_mask;
    logic             last_entry, poll_match, poll_retry, aw_done, w_done;
    state_t           adv_state;

    always_ff @(posedge clk_i) rom_q <= rom[idx_q];

    assign {ent_op, ent_addr, ent_data, ent_mask} = rom_q;

    assign idx_d      = idx_q + IW'(1);
    // Finishing the last slot without an END behaves as if END followed.
    assign last_entry = (idx_q == IW'(N - 1));
    assign adv_state  = last_entry ? S_DONE : S_FETCH;
    assign poll_match = ((s_axi_rdata_i & ent_mask_q) == (ent_data_q & ent_mask_q));
    // attempt_q counts retries already issued, so POLL_MAX bounds the total reads.
    assign poll_retry = (int'(attempt_q) + 1) < POLL_MAX;
    assign aw_done    = !awvalid_q || s_axi_awready_i;
    assign w_done     = !wvalid_q || s_axi_wready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            err_idx_q  <= '0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            ent_data_q <= '0;
            ent_mask_q <= '0;
            attempt_q  <= '0;
            dly_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q    <= S_FETCH;
                        idx_q      <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        err_idx_q  <= '0;
                    end
                end
                S_FETCH: state_q <= S_EXEC;
                S_EXEC: begin
                    ent_data_q <= ent_data;
                    ent_mask_q <= ent_mask;
                    attempt_q  <= '0;
                    case (ent_op)
                        OP_WRITE: begin
                            awaddr_q  <= ent_addr;
                            wdata_q   <= ent_data;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR;
                        end
                        OP_POLL: begin
                            araddr_q  <= ent_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD;
                        end
                        OP_DELAY: begin
                            dly_q   <= ent_data[15:0];
                            state_q <= S_DELAY;
                        end
                        default: begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    endcase
                end
                S_WR: begin
                    if (s_axi_awready_i) awvalid_q <= 1'b0;
                    if (s_axi_wready_i) wvalid_q <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_BRSP;
                    end
                end
                S_BRSP: begin
                    if (s_axi_bvalid_i) begin
                        bready_q <= 1'b0;
                        if (s_axi_bresp_i != 2'b00) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_BRESP;
                            err_idx_q  <= idx_q;
                            state_q    <= S_ERR;
                        end else begin
                            idx_q   <= idx_d;
                            done_q  <= last_entry;
                            state_q <= adv_state;
                        end
                    end
                end
                S_RD: begin
                    if (s_axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RRSP;
                    end
                end
                S_RRSP: begin
                    if (s_axi_rvalid_i) begin
                        rready_q <= 1'b0;
                        if (s_axi_rresp_i != 2'b00) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RRESP;
                            err_idx_q  <= idx_q;
                            state_q    <= S_ERR;
                        end else if (poll_match) begin
                            idx_q   <= idx_d;
                            done_q  <= last_entry;
                            state_q <= adv_state;
                        end else if (poll_retry) begin
                            attempt_q <= attempt_q + CW'(1);
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_POLL;
                            err_idx_q  <= idx_q;
                            state_q    <= S_ERR;
                        end
                    end
                end
                S_DELAY: begin
                    // Exit on 1 rather than 0 so a load of D spends exactly D cycles here.
                    if (dly_q <= 16'd1) begin
                        idx_q   <= idx_d;
                        done_q  <= last_entry;
                        state_q <= adv_state;
                    end else begin
                        dly_q <= dly_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign err_code_o      = err_code_q;
    assign err_idx_o       = err_idx_q;
    assign s_axi_awaddr_o  = awaddr_q;
    assign s_axi_awvalid_o = awvalid_q;
    assign s_axi_wdata_o   = wdata_q;
    assign s_axi_wstrb_o   = '1;
    assign s_axi_wvalid_o  = wvalid_q;
    assign s_axi_bready_o  = bready_q;
    assign s_axi_araddr_o  = araddr_q;
    assign s_axi_arvalid_o = arvalid_q;
    assign s_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi4lite_seq.sv
// Directed bench for axi4lite_seq: scripted slave plus queue-based scoreboard on AW/W/AR handshakes.
module tb_axi4lite_seq;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [3:0]  err_idx_o;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;

    axi4lite_seq #(.N(16), .ADDRW(8), .DATAW(32), .POLL_MAX(4), .INIT_FILE("")) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .err_idx_o(err_idx_o),
        .s_axi_awaddr_o(awaddr), .s_axi_awvalid_o(awvalid), .s_axi_awready_i(awready),
        .s_axi_wdata_o(wdata), .s_axi_wstrb_o(wstrb), .s_axi_wvalid_o(wvalid),
        .s_axi_wready_i(wready), .s_axi_bresp_i(bresp), .s_axi_bvalid_i(bvalid),
        .s_axi_bready_o(bready), .s_axi_araddr_o(araddr), .s_axi_arvalid_o(arvalid),
        .s_axi_arready_i(arready), .s_axi_rdata_i(rdata), .s_axi_rresp_i(rresp),
        .s_axi_rvalid_i(rvalid), .s_axi_rready_o(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard queues (pushed by stimulus, popped by monitor)
    logic [7:0]  exp_aw[$];
    logic [31:0] exp_w[$];
    logic [7:0]  exp_ar[$];
    // Slave response scripts
    logic [1:0]  bresp_q[$];
    logic [31:0] rd_vals[$];
    int          b_cyc_q[$];
    int          aw_rise_q[$];

    int aw_lat = 0, w_lat = 0, ar_lat = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [73:0] ent(input logic [1:0] op, input logic [7:0] a,
                                        input logic [31:0] d, input logic [31:0] m);
        return {op, a, d, m};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) dut.rom[i] = ent(2'd3, 8'h00, 32'h0, 32'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_o || err_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, " finished in budget"}, 64'(seen), 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Slave model: readies at negedge, handshakes land on the following posedge.
    initial begin : slave
        bit pend_aw, pend_w, pend_b, pend_ar, pend_r, got_aw, got_w, r_owed;
        int aw_wait, w_wait, ar_wait;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        {pend_aw, pend_w, pend_b, pend_ar, pend_r, got_aw, got_w, r_owed} = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                {pend_aw, pend_w, pend_b, pend_ar, pend_r, got_aw, got_w, r_owed} = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (pend_aw) begin aw_cnt++; awready = 0; got_aw = 1; aw_wait = 0; end
                if (pend_w)  begin w_cnt++;  wready = 0;  got_w = 1;  w_wait = 0;  end
                if (pend_b)  bvalid = 0;
                if (pend_ar) begin ar_cnt++; arready = 0; r_owed = 1; ar_wait = 0; end
                if (pend_r)  rvalid = 0;
                if (got_aw && got_w && !bvalid) begin
                    bvalid = 1;
                    bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    got_aw = 0; got_w = 0;
                end
                if (r_owed && !rvalid) begin
                    rvalid = 1;
                    rdata = (rd_vals.size() > 0) ? rd_vals.pop_front() : 32'h0;
                    rresp = 2'b00;
                    r_owed = 0;
                end
                if (awvalid && !awready) begin
                    if (aw_wait >= aw_lat) awready = 1; else aw_wait++;
                end
                if (wvalid && !wready) begin
                    if (w_wait >= w_lat) wready = 1; else w_wait++;
                end
                if (arvalid && !arready) begin
                    if (ar_wait >= ar_lat) arready = 1; else ar_wait++;
                end
                pend_aw = awvalid && awready;
                pend_w  = wvalid && wready;
                pend_b  = bvalid && bready;
                pend_ar = arvalid && arready;
                pend_r  = rvalid && rready;
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard queues.
    initial begin : monitor
        logic aw_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) chk("unexpected AW addr", 64'(awaddr), 64'hFFFF);
                else chk("AW addr", 64'(awaddr), 64'(exp_aw.pop_front()));
            end
            if (wvalid && wready) begin
                chk("W strb", 64'(wstrb), 64'hF);
                if (exp_w.size() == 0) chk("unexpected W data", 64'(wdata), 64'h1_0000_0000);
                else chk("W data", 64'(wdata), 64'(exp_w.pop_front()));
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) chk("unexpected AR addr", 64'(araddr), 64'hFFFF);
                else chk("AR addr", 64'(araddr), 64'(exp_ar.pop_front()));
            end
            if (bvalid && bready) b_cyc_q.push_back(cyc);
            if (awvalid && !aw_prev) aw_rise_q.push_back(cyc);
            aw_prev = awvalid;
        end
    end

    initial begin : main
        int a0, b0, r0, base;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(busy_o), 0);
        chk("reset done/err", 64'({done_o, err_o}), 0);
        chk("reset err code/idx", 64'({err_code_o, err_idx_o}), 0);
        chk("reset valids/readys", 64'({awvalid, wvalid, bready, arvalid, rready}), 0);
        repeat (10) @(negedge clk);
        chk("no auto-start", 64'({busy_o, awvalid, arvalid}), 0);

        // Single write; AW accepted one cycle before W
        clear_rom();
        dut.rom[0] = ent(2'd0, 8'h04, 32'hDEADBEEF, 32'h0);
        aw_lat = 0; w_lat = 1;
        exp_aw.push_back(8'h04); exp_w.push_back(32'hDEADBEEF);
        a0 = aw_cnt; base = w_cnt;
        pulse_start();
        wait_end("write");
        chk("write done", 64'({done_o, err_o, busy_o}), 64'b100);
        chk("write AW count", 64'(aw_cnt - a0), 1);
        chk("write W count", 64'(w_cnt - base), 1);
        w_lat = 0;

        // Poll that matches on the third read, then the next entry runs
        clear_rom();
        dut.rom[0] = ent(2'd1, 8'h10, 32'h1, 32'h1);
        dut.rom[1] = ent(2'd0, 8'h20, 32'h55, 32'h0);
        rd_vals.push_back(32'h0); rd_vals.push_back(32'hFFFF_FFFE); rd_vals.push_back(32'h8000_0001);
        repeat (3) exp_ar.push_back(8'h10);
        exp_aw.push_back(8'h20); exp_w.push_back(32'h55);
        r0 = ar_cnt;
        pulse_start();
        wait_end("poll");
        chk("poll AR count", 64'(ar_cnt - r0), 3);
        chk("poll done", 64'({done_o, err_o}), 64'b10);

        // Poll timeout after POLL_MAX=4 reads, entry 1
        clear_rom();
        dut.rom[0] = ent(2'd0, 8'h30, 32'h1, 32'h0);
        dut.rom[1] = ent(2'd1, 8'h44, 32'hA, 32'hF);
        dut.rom[2] = ent(2'd0, 8'h50, 32'h2, 32'h0);
        exp_aw.push_back(8'h30); exp_w.push_back(32'h1);
        repeat (4) begin rd_vals.push_back(32'h5); exp_ar.push_back(8'h44); end
        r0 = ar_cnt; a0 = aw_cnt;
        pulse_start();
        wait_end("timeout");
        chk("timeout err/done", 64'({err_o, done_o}), 64'b10);
        chk("timeout code", 64'(err_code_o), 3);
        chk("timeout idx", 64'(err_idx_o), 1);
        repeat (20) @(negedge clk);
        chk("timeout AR count", 64'(ar_cnt - r0), 4);
        chk("timeout no later write", 64'(aw_cnt - a0), 1);
        chk("timeout err held", 64'({err_o, busy_o, arvalid}), 64'b100);

        // BRESP error, then restart reruns from entry 0
        clear_rom();
        dut.rom[0] = ent(2'd0, 8'h60, 32'h11, 32'h0);
        dut.rom[1] = ent(2'd0, 8'h64, 32'h22, 32'h0);
        bresp_q.push_back(2'b10);
        exp_aw.push_back(8'h60); exp_w.push_back(32'h11);
        a0 = aw_cnt;
        pulse_start();
        wait_end("bresp");
        chk("bresp code", 64'(err_code_o), 1);
        chk("bresp idx", 64'(err_idx_o), 0);
        repeat (5) @(negedge clk);
        chk("bresp AW count", 64'(aw_cnt - a0), 1);
        exp_aw.push_back(8'h60); exp_w.push_back(32'h11);
        exp_aw.push_back(8'h64); exp_w.push_back(32'h22);
        a0 = aw_cnt;
        pulse_start();
        wait_end("rerun");
        chk("rerun status", 64'({done_o, err_o, err_code_o}), 64'b1000);
        chk("rerun AW count", 64'(aw_cnt - a0), 2);

        // DELAY 5 and DELAY 0 between two writes
        for (int k = 0; k < 2; k++) begin
            clear_rom();
            dut.rom[0] = ent(2'd0, 8'h70, 32'hA, 32'h0);
            dut.rom[1] = ent(2'd2, 8'h00, (k == 0) ? 32'h5 : 32'h0, 32'h0);
            dut.rom[2] = ent(2'd0, 8'h74, 32'hB, 32'h0);
            exp_aw.push_back(8'h70); exp_w.push_back(32'hA);
            exp_aw.push_back(8'h74); exp_w.push_back(32'hB);
            a0 = aw_rise_q.size(); b0 = b_cyc_q.size();
            pulse_start();
            wait_end("delay");
            chk("delay AW rises", 64'(aw_rise_q.size() - a0), 2);
            if (aw_rise_q.size() >= a0 + 2 && b_cyc_q.size() >= b0 + 1)
                chk((k == 0) ? "delay5 gap" : "delay0 gap",
                    64'(aw_rise_q[a0+1] - b_cyc_q[b0]), (k == 0) ? 64'd10 : 64'd6);
        end

        // Reset while AWVALID is high
        clear_rom();
        dut.rom[0] = ent(2'd0, 8'h80, 32'h1234, 32'h0);
        aw_lat = 50; w_lat = 50;
        pulse_start();
        for (int i = 0; i < 20 && !awvalid; i++) @(negedge clk);
        chk("awvalid before reset", 64'(awvalid), 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid-reset valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 0);
        chk("mid-reset status", 64'({busy_o, done_o, err_o}), 0);
        chk("mid-reset addr/data", 64'({awaddr, araddr, wdata}), 0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("post-reset idle", 64'({busy_o, awvalid, wvalid}), 0);
        aw_lat = 0; w_lat = 0;

        // start_i while in RD is ignored
        clear_rom();
        dut.rom[0] = ent(2'd1, 8'h90, 32'h3, 32'h3);
        rd_vals.push_back(32'h7);
        exp_ar.push_back(8'h90);
        ar_lat = 8;
        r0 = ar_cnt;
        pulse_start();
        for (int i = 0; i < 20 && !arvalid; i++) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("RD ignores start", 64'({arvalid, busy_o}), 64'b11);
        wait_end("rd start");
        chk("RD start AR count", 64'(ar_cnt - r0), 1);
        chk("RD start done", 64'({done_o, err_o}), 64'b10);
        ar_lat = 0;

        repeat (5) @(negedge clk);
        chk("scoreboard drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
